// File: rtl/pkt_seq_checker_if.sv
// rtl/pkt_seq_checker_if.sv - packet bus carrying data_bus/valid into the sequence checker
interface pkt_seq_checker_if #(
    parameter int BUS_SIZE = 16
);
    logic [BUS_SIZE-1:0] data_bus;
    logic                valid;

    modport master (
        output data_bus,
        output valid
    );

    modport slave (
        input data_bus,
        input valid
    );
endinterface

// File: rtl/pkt_seq_checker.sv
// rtl/pkt_seq_checker.sv - per-channel packet sequence checker with lock tracking and error reporting
module pkt_seq_checker #(
    parameter int BUS_SIZE    = 16,
    parameter int WORD_SIZE   = 4,
    parameter int NUM_CH      = 4,
    parameter int LOCK_THRESH = 2,
    parameter int CNT_W       = 8,
    parameter logic [WORD_SIZE-1:0] FLAG_CODE = {WORD_SIZE{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    pkt_seq_checker_if.slave     pkt,
    input  logic                 clear,
    output logic                 err_pulse,
    output logic [1:0]           err_type,
    output logic [WORD_SIZE-1:0] err_ch,
    output logic                 error_sticky,
    output logic [CNT_W-1:0]     err_count,
    output logic [NUM_CH-1:0]    ch_locked
);

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_LOCK = 2'd1,
        CH_ERR  = 2'd2
    } ch_state_t;

    localparam logic [1:0]           E_NONE   = 2'd0;
    localparam logic [1:0]           E_FLAG   = 2'd1;
    localparam logic [1:0]           E_RANGE  = 2'd2;
    localparam logic [1:0]           E_SEQ    = 2'd3;
    localparam logic [3:0]           THRESH   = 4'(LOCK_THRESH);
    localparam logic [WORD_SIZE:0]   NUM_CH_W = (WORD_SIZE+1)'(NUM_CH);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    // Packet fields; bits between channel and flag carry no meaning here.
    logic [WORD_SIZE-1:0] pkt_flag;
    logic [WORD_SIZE-1:0] pkt_ch;
    logic [WORD_SIZE-1:0] pkt_seq;
    logic                 unused_bits;

    assign pkt_flag    = pkt.data_bus[BUS_SIZE-1 -: WORD_SIZE];
    assign pkt_ch      = pkt.data_bus[2*WORD_SIZE-1:WORD_SIZE];
    assign pkt_seq     = pkt.data_bus[WORD_SIZE-1:0];
    assign unused_bits = ^pkt.data_bus;

    // Per-channel tracking state.
    ch_state_t            state    [NUM_CH];
    logic [WORD_SIZE-1:0] exp_seq  [NUM_CH];
    logic [3:0]           good_run [NUM_CH];

    ch_state_t            nxt_state [NUM_CH];
    logic [WORD_SIZE-1:0] nxt_exp   [NUM_CH];
    logic [3:0]           nxt_run   [NUM_CH];

    logic                 flag_bad;
    logic                 range_bad;
    logic                 seq_err;
    logic [1:0]           ev_type;
    logic                 ev_err;
    logic [WORD_SIZE-1:0] ev_ch;

    // Classify the current packet and compute the next state of the addressed channel.
    always_comb begin
        flag_bad  = (pkt_flag != FLAG_CODE);
        range_bad = ({1'b0, pkt_ch} >= NUM_CH_W);
        seq_err   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            nxt_state[i] = state[i];
            nxt_exp[i]   = exp_seq[i];
            nxt_run[i]   = good_run[i];
            if (pkt.valid && !flag_bad && !range_bad && (pkt_ch == WORD_SIZE'(i))) begin
                nxt_exp[i] = pkt_seq + 1'b1;
                if (state[i] == CH_LOCK) begin
                    // A locked channel that skips or repeats drops back to acquiring.
                    if (pkt_seq != exp_seq[i]) begin
                        nxt_state[i] = CH_ERR;
                        nxt_run[i]   = 4'd1;
                        seq_err      = 1'b1;
                    end
                end else begin
                    // Acquiring: an out-of-order packet restarts the run at itself.
                    nxt_run[i] = (pkt_seq == exp_seq[i]) ? good_run[i] + 4'd1 : 4'd1;
                    if (nxt_run[i] == THRESH) begin
                        nxt_state[i] = CH_LOCK;
                    end
                end
            end
        end

        if (!pkt.valid) begin
            ev_type = E_NONE;
        end else if (flag_bad) begin
            ev_type = E_FLAG;
        end else if (range_bad) begin
            ev_type = E_RANGE;
        end else if (seq_err) begin
            ev_type = E_SEQ;
        end else begin
            ev_type = E_NONE;
        end
        ev_err = (ev_type != E_NONE);
        ev_ch  = (ev_type == E_RANGE || ev_type == E_SEQ) ? pkt_ch : '0;
    end

    // Channel state machines plus the registered lock decode, updated together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]    <= CH_IDLE;
                exp_seq[i]  <= '0;
                good_run[i] <= '0;
            end
            ch_locked <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]     <= nxt_state[i];
                exp_seq[i]   <= nxt_exp[i];
                good_run[i]  <= nxt_run[i];
                ch_locked[i] <= (nxt_state[i] == CH_LOCK);
            end
        end
    end

    // Registered error event outputs, sticky flag and saturating counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_pulse    <= 1'b0;
            err_type     <= E_NONE;
            err_ch       <= '0;
            error_sticky <= 1'b0;
            err_count    <= '0;
        end else begin
            err_pulse <= ev_err;
            err_type  <= ev_type;
            err_ch    <= ev_ch;
            if (clear) begin
                // An error coinciding with clear survives as the first new event.
                error_sticky <= ev_err;
                err_count    <= ev_err ? CNT_W'(1) : '0;
            end else begin
                error_sticky <= error_sticky | ev_err;
                if (ev_err && (err_count != CNT_MAX)) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_seq_checker.sv
// tb/tb_pkt_seq_checker.sv - self-checking bench for pkt_seq_checker across three configurations
module tb_pkt_seq_checker;

    logic clk;
    logic reset;
    logic clear;

    int checks;
    int errors;

    pkt_seq_checker_if #(.BUS_SIZE(16)) bus ();

    // Config 0: defaults. Config 1: 3 channels, 2-bit counter. Config 2: 16 channels, lock on first packet.
    logic       pulse_a, pulse_b, pulse_c;
    logic [1:0] type_a, type_b, type_c;
    logic [3:0] ch_a, ch_b, ch_c;
    logic       sticky_a, sticky_b, sticky_c;
    logic [7:0] count_a, count_c;
    logic [1:0] count_b;
    logic [3:0] lock_a;
    logic [2:0] lock_b;
    logic [15:0] lock_c;

    pkt_seq_checker dut_a (
        .clk(clk), .reset(reset), .pkt(bus), .clear(clear),
        .err_pulse(pulse_a), .err_type(type_a), .err_ch(ch_a),
        .error_sticky(sticky_a), .err_count(count_a), .ch_locked(lock_a)
    );

    pkt_seq_checker #(.NUM_CH(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .pkt(bus), .clear(clear),
        .err_pulse(pulse_b), .err_type(type_b), .err_ch(ch_b),
        .error_sticky(sticky_b), .err_count(count_b), .ch_locked(lock_b)
    );

    pkt_seq_checker #(.NUM_CH(16), .LOCK_THRESH(1)) dut_c (
        .clk(clk), .reset(reset), .pkt(bus), .clear(clear),
        .err_pulse(pulse_c), .err_type(type_c), .err_ch(ch_c),
        .error_sticky(sticky_c), .err_count(count_c), .ch_locked(lock_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per config, which channels are locked, the next expected seq and the run length.
    int   cfg_nch  [3] = '{4, 3, 16};
    int   cfg_cmax [3] = '{255, 3, 255};
    int   cfg_th   [3] = '{2, 2, 1};

    bit         m_lock  [3][16];
    logic [3:0] m_exp   [3][16];
    int         m_run   [3][16];
    int         e_pulse [3];
    int         e_type  [3];
    int         e_ch    [3];
    int         e_sticky[3];
    int         e_count [3];

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int c = 0; c < 16; c++) begin
                m_lock[m][c] = 1'b0;
                m_exp[m][c]  = 4'd0;
                m_run[m][c]  = 0;
            end
            e_pulse[m] = 0; e_type[m] = 0; e_ch[m] = 0; e_sticky[m] = 0; e_count[m] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic c);
        int typ, ech, ch;
        logic [3:0] seq;
        for (int m = 0; m < 3; m++) begin
            typ = 0; ech = 0;
            ch  = int'(d[7:4]);
            seq = d[3:0];
            if (v) begin
                if (d[15:12] != 4'hF) begin
                    typ = 1;
                end else if (ch >= cfg_nch[m]) begin
                    typ = 2; ech = ch;
                end else if (m_lock[m][ch]) begin
                    if (seq != m_exp[m][ch]) begin
                        typ = 3; ech = ch;
                        m_lock[m][ch] = 1'b0;
                        m_run[m][ch]  = 1;
                    end
                    m_exp[m][ch] = seq + 4'd1;
                end else begin
                    m_run[m][ch] = (seq == m_exp[m][ch]) ? m_run[m][ch] + 1 : 1;
                    m_exp[m][ch] = seq + 4'd1;
                    if (m_run[m][ch] == cfg_th[m]) m_lock[m][ch] = 1'b1;
                end
            end
            e_pulse[m] = (typ != 0) ? 1 : 0;
            e_type[m]  = typ;
            e_ch[m]    = ech;
            if (c) begin
                e_sticky[m] = e_pulse[m];
                e_count[m]  = e_pulse[m];
            end else begin
                if (e_pulse[m] == 1) e_sticky[m] = 1;
                if (e_pulse[m] == 1 && e_count[m] < cfg_cmax[m]) e_count[m] = e_count[m] + 1;
            end
        end
    endtask

    function automatic int model_lockvec(input int m);
        int lv;
        lv = 0;
        for (int c = 0; c < 16; c++) begin
            if (c < cfg_nch[m] && m_lock[m][c]) lv = lv | (1 << c);
        end
        return lv;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int a_p, a_t, a_c, a_s, a_n, a_l;
        for (int m = 0; m < 3; m++) begin
            case (m)
                0: begin a_p = int'(pulse_a); a_t = int'(type_a); a_c = int'(ch_a);
                         a_s = int'(sticky_a); a_n = int'(count_a); a_l = int'(lock_a); end
                1: begin a_p = int'(pulse_b); a_t = int'(type_b); a_c = int'(ch_b);
                         a_s = int'(sticky_b); a_n = int'(count_b); a_l = int'(lock_b); end
                default: begin a_p = int'(pulse_c); a_t = int'(type_c); a_c = int'(ch_c);
                         a_s = int'(sticky_c); a_n = int'(count_c); a_l = int'(lock_c); end
            endcase
            chk($sformatf("cfg%0d err_pulse", m), a_p, e_pulse[m]);
            chk($sformatf("cfg%0d err_type", m), a_t, e_type[m]);
            chk($sformatf("cfg%0d err_ch", m), a_c, e_ch[m]);
            chk($sformatf("cfg%0d error_sticky", m), a_s, e_sticky[m]);
            chk($sformatf("cfg%0d err_count", m), a_n, e_count[m]);
            chk($sformatf("cfg%0d ch_locked", m), a_l, model_lockvec(m));
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic c);
        bus.valid    = v;
        bus.data_bus = d;
        clear        = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_all();
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        int          p;
        int          t;
        int          ch;
        int          lk;
        int          cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [3:0] ch, sq, fl;
        checks = 0;
        errors = 0;

        // Lock/wrap/seq-error/flag-error walk for the default configuration.
        tbl[0]  = '{1'b1, 16'hF005, 0, 0, 0, 4'b0000, 0};
        tbl[1]  = '{1'b1, 16'hF006, 0, 0, 0, 4'b0001, 0};
        tbl[2]  = '{1'b1, 16'hF007, 0, 0, 0, 4'b0001, 0};
        tbl[3]  = '{1'b0, 16'hFFFF, 0, 0, 0, 4'b0001, 0};
        tbl[4]  = '{1'b1, 16'hF02E, 0, 0, 0, 4'b0001, 0};
        tbl[5]  = '{1'b1, 16'hF02F, 0, 0, 0, 4'b0101, 0};
        tbl[6]  = '{1'b1, 16'hF020, 0, 0, 0, 4'b0101, 0};
        tbl[7]  = '{1'b1, 16'hF021, 0, 0, 0, 4'b0101, 0};
        tbl[8]  = '{1'b1, 16'hF023, 1, 3, 2, 4'b0001, 1};
        tbl[9]  = '{1'b1, 16'hF015, 0, 0, 0, 4'b0001, 1};
        tbl[10] = '{1'b1, 16'hF016, 0, 0, 0, 4'b0011, 1};
        tbl[11] = '{1'b1, 16'hE017, 1, 1, 0, 4'b0011, 2};
        tbl[12] = '{1'b1, 16'hF017, 0, 0, 0, 4'b0011, 2};

        reset        = 1'b0;
        clear        = 1'b0;
        bus.valid    = 1'b0;
        bus.data_bus = 16'h0000;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #2;
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].v, tbl[i].d, 1'b0);
            chk($sformatf("vec%0d err_pulse", i), int'(pulse_a), tbl[i].p);
            chk($sformatf("vec%0d err_type", i), int'(type_a), tbl[i].t);
            chk($sformatf("vec%0d err_ch", i), int'(ch_a), tbl[i].ch);
            chk($sformatf("vec%0d ch_locked", i), int'(lock_a), tbl[i].lk);
            chk($sformatf("vec%0d err_count", i), int'(count_a), tbl[i].cnt);
        end

        // Channel 3 is out of range for the 3-channel configuration.
        cycle(1'b1, 16'hF035, 1'b0);
        chk("range err_type", int'(type_b), 2);
        chk("range err_ch", int'(ch_b), 3);

        // Saturation of the 2-bit counter, then clear alone, then clear with a coinciding error.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0000, 1'b0);
        chk("sat err_count", int'(count_b), 3);
        cycle(1'b0, 16'h0000, 1'b1);
        chk("clear err_count", int'(count_b), 0);
        chk("clear error_sticky", int'(sticky_b), 0);
        cycle(1'b1, 16'h0000, 1'b1);
        chk("clear+err err_count", int'(count_b), 1);
        chk("clear+err error_sticky", int'(sticky_b), 1);

        // Asynchronous reset between edges while channels are locked.
        bus.valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("async err_pulse", int'(pulse_a), 0);
        chk("async err_type", int'(type_a), 0);
        chk("async err_count", int'(count_a), 0);
        chk("async error_sticky", int'(sticky_a), 0);
        chk("async ch_locked", int'(lock_a), 0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        cycle(1'b1, 16'hF009, 1'b0);
        chk("post-reset err_pulse", int'(pulse_a), 0);
        chk("post-reset ch_locked", int'(lock_a), 0);

        // Randomized traffic, biased toward in-order packets so channels lock and break.
        for (int i = 0; i < 600; i++) begin
            ch = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 9) < 7) sq = m_exp[0][ch];
            else                          sq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) fl = 4'($urandom_range(0, 15));
            else                           fl = 4'hF;
            cycle($urandom_range(0, 3) != 0,
                  {fl, 4'($urandom_range(0, 15)), ch, sq},
                  $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_seq_checker.md
PKT_SEQ_CHECKER -- requirements
Module: pkt_seq_checker

Interface
REQ-001 Parameter BUS_SIZE, default 16: input bus width in bits.
REQ-002 Parameter WORD_SIZE, default 4: width of the flag, channel and sequence fields.
REQ-003 Parameter NUM_CH, default 4: number of independently tracked channels; 1..2^WORD_SIZE.
REQ-004 Parameter LOCK_THRESH, default 2: consecutive in-order packets needed to lock a channel; 1..15.
REQ-005 Parameter CNT_W, default 8: width of the error counter.
REQ-006 Parameter FLAG_CODE, default all ones (WORD_SIZE bits): required flag value.
REQ-007 Legal configurations satisfy BUS_SIZE >= 3*WORD_SIZE.
REQ-008 clk  input  1  clock; all state updates occur on the rising edge.
REQ-009 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-010 data_bus  input  BUS_SIZE  packet: flag = [BUS_SIZE-1 -: WORD_SIZE], channel = [2*WORD_SIZE-1:WORD_SIZE], seq = [WORD_SIZE-1:0]; other bits ignored.
REQ-011 valid  input  1  data_bus holds a packet this cycle.
REQ-012 clear  input  1  synchronous clear of error_sticky and err_count.
REQ-013 err_pulse  output  1  one-cycle error event indication.
REQ-014 err_type  output  2  event cause: 0 none, 1 flag, 2 channel range, 3 sequence.
REQ-015 err_ch  output  WORD_SIZE  channel field of the erroring packet; 0 for flag errors.
REQ-016 error_sticky  output  1  set on any error, held until clear.
REQ-017 err_count  output  CNT_W  saturating error event count.
REQ-018 ch_locked  output  NUM_CH  bit i high while channel i is in LOCK.

Function
REQ-019 Packets with valid=0 are ignored; no state changes except through clear.
REQ-020 Checks apply in priority order: flag != FLAG_CODE -> type 1; else channel >= NUM_CH -> type 2; else per-channel sequence check.
REQ-021 Type 1 and type 2 errors leave all channel states unchanged.
REQ-022 Each channel has a state (IDLE, LOCK, ERR), an expected seq (WORD_SIZE bits) and a good-run counter.
REQ-023 IDLE/ERR (acquiring): seq == expected -> good_run+1, expected <= seq+1; else good_run <= 1, expected <= seq+1; neither case reports an error.
REQ-024 Acquiring: when the updated good_run equals LOCK_THRESH, the channel moves to LOCK on the same edge; with LOCK_THRESH=1 the first packet locks.
REQ-025 LOCK: seq == expected -> expected <= seq+1, remain in LOCK.
REQ-026 LOCK: seq != expected -> ERR, type 3 error, expected <= seq+1, good_run <= 1.
REQ-027 Sequence arithmetic wraps modulo 2^WORD_SIZE (15 followed by 0 is in order for WORD_SIZE=4).
REQ-028 Error outputs are registered: err_pulse, err_type and err_ch are valid in the cycle after the erroring packet edge; err_pulse=0 and err_type=0 otherwise.
REQ-029 err_count increments by 1 per error event and saturates at 2^CNT_W-1.
REQ-030 clear without error: error_sticky <= 0, err_count <= 0.
REQ-031 clear with an error in the same cycle: error_sticky <= 1, err_count <= 1.
REQ-032 ch_locked is a registered decode of the channel states.
REQ-033 Latency from packet to err_pulse or ch_locked change is 1 clock.

Reset
REQ-034 reset=0 asynchronously forces all channels to IDLE, expected=0, good_run=0.
REQ-035 reset=0 asynchronously forces all outputs to 0.
REQ-036 Assertion mid-stream discards all tracking; the first post-reset packet is handled as in IDLE.
REQ-037 Release is sampled on clk; a packet presented on the first edge after release is processed.

Verification
REQ-038 Defaults; ch0 seqs 5,6,7 -> ch_locked[0]=1 one cycle after seq 6; no err_pulse.
REQ-039 ch2 locked; seqs 14,15,0,1 -> no error (wrap); then seq 3 -> err_pulse=1, err_type=3, err_ch=2, ch_locked[2]=0, err_count=1.
REQ-040 Flag 0xE with ch1 locked -> err_type=1, err_ch=0; ch_locked[1] unchanged; next in-order ch1 packet -> no error.
REQ-041 NUM_CH=3, channel field 3 -> err_type=2, err_ch=3; no channel state change.
REQ-042 CNT_W=2, five errors -> err_count=3; clear alone -> 0; clear plus error in the same cycle -> err_count=1, error_sticky=1.
REQ-043 Locked channels, reset=0 between edges -> outputs 0 immediately; after release, ch0 seq 9 -> no error, ch_locked[0]=0.
